// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter for one SDRAM core inport, with in-order response routing.
// Latency: zero added on the request path; responses routed combinationally on core ack.
// Backpressure: a presented request is held until the core accepts it; new requests stall when MAX_OUTSTAND are in flight.

// In-order ID FIFO: 1-bit issuer tags, pointers carry an extra wrap bit to separate full from empty.
module sdram_arb_id_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic push_dat_i,
  input  logic pop_i,
  output logic head_dat_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] mem_q, mem_d;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state: push writes at the tail, pop advances the head; both may happen together.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_i) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat_i;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer and storage registers; reset drops any in-flight tags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end
endmodule

module sdram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_OUTSTAND = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // port 0 (CPU)
  input  logic [3:0]        p0_wr_i,
  input  logic              p0_rd_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_wdata_i,
  output logic              p0_accept_o,
  output logic              p0_ack_o,
  output logic              p0_error_o,
  output logic [DATA_W-1:0] p0_rdata_o,
  // port 1 (DMA/video)
  input  logic [3:0]        p1_wr_i,
  input  logic              p1_rd_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_wdata_i,
  output logic              p1_accept_o,
  output logic              p1_ack_o,
  output logic              p1_error_o,
  output logic [DATA_W-1:0] p1_rdata_o,
  // SDRAM core inport
  output logic [3:0]        core_wr_o,
  output logic              core_rd_o,
  output logic [ADDR_W-1:0] core_addr_o,
  output logic [DATA_W-1:0] core_wdata_o,
  input  logic              core_accept_i,
  input  logic              core_ack_i,
  input  logic              core_error_i,
  input  logic [DATA_W-1:0] core_rdata_i,
  // status
  output logic              busy_o,
  output logic              proto_err_o
);

  logic              last_q, last_d;
  logic              lock_q, lock_d;
  logic              lock_id_q, lock_id_d;
  logic              proto_err_q, proto_err_d;

  logic              p0_req, p1_req;
  logic              grant;
  logic              g_req;
  logic [3:0]        g_wr;
  logic              g_rd;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic              present;
  logic              accept;
  logic              pop;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_head;

  assign p0_req = (p0_wr_i != 4'h0) || p0_rd_i;
  assign p1_req = (p1_wr_i != 4'h0) || p1_rd_i;

  // Grant select: a locked port keeps the core; otherwise alternate on contention.
  always_comb begin
    grant = 1'b0;
    if (lock_q) begin
      grant = lock_id_q;
    end else if (p0_req && p1_req) begin
      grant = ~last_q;
    end else if (p1_req) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
  end

  // Mux the granted port's request fields.
  always_comb begin
    g_req   = p0_req;
    g_wr    = p0_wr_i;
    g_rd    = p0_rd_i;
    g_addr  = p0_addr_i;
    g_wdata = p0_wdata_i;
    if (grant) begin
      g_req   = p1_req;
      g_wr    = p1_wr_i;
      g_rd    = p1_rd_i;
      g_addr  = p1_addr_i;
      g_wdata = p1_wdata_i;
    end
  end

  // A request reaches the core only when a free ID slot exists; the reset gate keeps the
  // core interface quiet while reset is held.
  assign present = g_req && !fifo_full && rst_ni;
  assign accept  = present && core_accept_i;

  assign core_wr_o    = present ? g_wr : 4'h0;
  // Write wins when a port sets both wr and rd.
  assign core_rd_o    = present && g_rd && (g_wr == 4'h0);
  assign core_addr_o  = g_addr;
  assign core_wdata_o = g_wdata;

  assign p0_accept_o = accept && !grant;
  assign p1_accept_o = accept &&  grant;

  // Responses: the FIFO head names the issuer of the oldest outstanding request.
  assign pop        = core_ack_i && !fifo_empty && rst_ni;
  assign p0_ack_o   = pop && !fifo_head;
  assign p1_ack_o   = pop &&  fifo_head;
  assign p0_error_o = pop && !fifo_head && core_error_i;
  assign p1_error_o = pop &&  fifo_head && core_error_i;
  assign p0_rdata_o = core_rdata_i;
  assign p1_rdata_o = core_rdata_i;

  assign busy_o      = !fifo_empty;
  assign proto_err_o = proto_err_q;

  sdram_arb_id_fifo #(
    .DEPTH (MAX_OUTSTAND)
  ) u_id_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (accept),
    .push_dat_i (grant),
    .pop_i      (pop),
    .head_dat_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Arbitration state: remember the last winner, lock a presented-but-stalled request.
  always_comb begin
    last_d      = last_q;
    lock_d      = lock_q;
    lock_id_d   = lock_id_q;
    proto_err_d = proto_err_q | (core_ack_i && fifo_empty);
    if (accept) begin
      last_d = grant;
      lock_d = 1'b0;
    end else if (present) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
  end

  // Arbiter registers; last_q resets to port 1 so port 0 wins the first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q      <= 1'b1;
      lock_q      <= 1'b0;
      lock_id_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      lock_q      <= lock_d;
      lock_id_q   <= lock_id_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Testbench for sdram_port_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (issuer queue, round-robin/lock rule, bounded outstanding count).
module tb_sdram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  p0_wr, p1_wr;
  logic        p0_rd, p1_rd;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
  logic        p0_accept, p1_accept, p0_ack, p1_ack, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [3:0]  core_wr;
  logic        core_rd;
  logic [31:0] core_addr, core_wdata;
  logic        core_accept, core_ack, core_error;
  logic [31:0] core_rdata;
  logic        busy, proto_err;

  int checks;
  int failures;

  sdram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTAND(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .p0_wr_i(p0_wr), .p0_rd_i(p0_rd), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
    .p0_accept_o(p0_accept), .p0_ack_o(p0_ack), .p0_error_o(p0_err), .p0_rdata_o(p0_rdata),
    .p1_wr_i(p1_wr), .p1_rd_i(p1_rd), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
    .p1_accept_o(p1_accept), .p1_ack_o(p1_ack), .p1_error_o(p1_err), .p1_rdata_o(p1_rdata),
    .core_wr_o(core_wr), .core_rd_o(core_rd), .core_addr_o(core_addr), .core_wdata_o(core_wdata),
    .core_accept_i(core_accept), .core_ack_i(core_ack), .core_error_i(core_error),
    .core_rdata_i(core_rdata),
    .busy_o(busy), .proto_err_o(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    p0_wr = 4'h0; p0_rd = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_wr = 4'h0; p1_rd = 1'b0; p1_addr = '0; p1_wdata = '0;
    core_accept = 1'b0; core_ack = 1'b0; core_error = 1'b0; core_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    p0_rd = 1'b1; core_accept = 1'b1; core_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (p0_accept !== 1'b0) begin failures++; $display("FAIL rst_accept got=%b exp=0", p0_accept); end
    checks++; if (core_rd !== 1'b0) begin failures++; $display("FAIL rst_core_rd got=%b exp=0", core_rd); end
    checks++; if (p0_ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", p0_ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rst_proto got=%b exp=0", proto_err); end
    idle_inputs();
    rst_n = 1'b1;
    #1;
    checks++; if (core_wr !== 4'h0) begin failures++; $display("FAIL rst_idle_core_wr got=%h exp=0", core_wr); end
    checks++; if (core_rd !== 1'b0) begin failures++; $display("FAIL rst_idle_core_rd got=%b exp=0", core_rd); end
    @(negedge clk);
  endtask

  task automatic test_single_port();
    logic [31:0] mem_word;
    do_reset();
    p0_wr = 4'hF; p0_addr = 32'h100; p0_wdata = 32'hDEADBEEF; core_accept = 1'b1;
    #1;
    checks++; if (p0_accept !== 1'b1) begin failures++; $display("FAIL sp_wr_accept got=%b exp=1", p0_accept); end
    checks++; if (p1_accept !== 1'b0) begin failures++; $display("FAIL sp_p1_accept got=%b exp=0", p1_accept); end
    checks++; if (core_wr !== 4'hF || core_rd !== 1'b0) begin failures++; $display("FAIL sp_core_wr got=%h/%b exp=f/0", core_wr, core_rd); end
    checks++; if (core_addr !== 32'h100) begin failures++; $display("FAIL sp_core_addr got=%h exp=100", core_addr); end
    checks++; if (core_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sp_core_wdata got=%h exp=deadbeef", core_wdata); end
    mem_word = core_wdata;
    @(negedge clk);
    idle_inputs(); core_ack = 1'b1;
    #1;
    checks++; if (p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_err !== 1'b0) begin failures++; $display("FAIL sp_wr_ack got=%b%b%b exp=100", p0_ack, p1_ack, p0_err); end
    @(negedge clk);
    idle_inputs(); p0_rd = 1'b1; p0_addr = 32'h100; core_accept = 1'b1;
    #1;
    checks++; if (p0_accept !== 1'b1 || core_rd !== 1'b1 || core_wr !== 4'h0) begin failures++; $display("FAIL sp_rd_req got=%b%b%h exp=110", p0_accept, core_rd, core_wr); end
    @(negedge clk);
    idle_inputs(); core_ack = 1'b1; core_rdata = mem_word;
    #1;
    checks++; if (p0_ack !== 1'b1 || p1_ack !== 1'b0) begin failures++; $display("FAIL sp_rd_ack got=%b%b exp=10", p0_ack, p1_ack); end
    checks++; if (p0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL sp_rdata got=%h exp=deadbeef", p0_rdata); end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sp_busy_end got=%b exp=0", busy); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int n0, n1, k, exp_port;
    logic exp_err;
    do_reset();
    n0 = 0; n1 = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      idle_inputs();
      core_accept = 1'b1;
      core_rdata  = $urandom;
      k = cyc - 3;
      exp_err = 1'b0;
      if (cyc >= 3 && k < 12) begin
        core_ack = 1'b1;
        exp_err = (k % 3 == 0);
        core_error = exp_err;
      end
      if (cyc < 12) begin
        p0_wr = 4'hF; p0_addr = 32'h1000 + 4 * n0; p0_wdata = $urandom;
        p1_rd = 1'b1; p1_addr = 32'h8000 + 4 * n1;
      end
      #1;
      if (cyc < 12) begin
        exp_port = cyc % 2;
        checks++; if (p0_accept !== (exp_port == 0) || p1_accept !== (exp_port == 1)) begin
          failures++; $display("FAIL cont_accept cyc=%0d got=%b%b exp_port=%0d", cyc, p0_accept, p1_accept, exp_port); end
        checks++; if (core_addr !== ((exp_port == 0) ? p0_addr : p1_addr)) begin
          failures++; $display("FAIL cont_addr cyc=%0d got=%h exp_port=%0d", cyc, core_addr, exp_port); end
        if (exp_port == 0) n0++; else n1++;
      end
      if (core_ack) begin
        exp_port = k % 2;
        checks++; if (p0_ack !== (exp_port == 0) || p1_ack !== (exp_port == 1)) begin
          failures++; $display("FAIL cont_ack cyc=%0d got=%b%b exp_port=%0d", cyc, p0_ack, p1_ack, exp_port); end
        checks++; if (p0_err !== (exp_port == 0 && exp_err) || p1_err !== (exp_port == 1 && exp_err)) begin
          failures++; $display("FAIL cont_err cyc=%0d got=%b%b exp_port=%0d err=%b", cyc, p0_err, p1_err, exp_port, exp_err); end
        checks++; if (p0_rdata !== core_rdata || p1_rdata !== core_rdata) begin
          failures++; $display("FAIL cont_rdata cyc=%0d got=%h/%h exp=%h", cyc, p0_rdata, p1_rdata, core_rdata); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lock();
    do_reset();
    p1_rd = 1'b1; p1_addr = 32'h2000; core_accept = 1'b0;
    #1;
    checks++; if (core_rd !== 1'b1 || core_addr !== 32'h2000) begin failures++; $display("FAIL lock_first got=%b/%h exp=1/2000", core_rd, core_addr); end
    @(negedge clk);
    p0_wr = 4'h3; p0_addr = 32'h3000; p0_wdata = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (core_addr !== 32'h2000 || core_rd !== 1'b1 || core_wr !== 4'h0 || p0_accept !== 1'b0 || p1_accept !== 1'b0) begin
        failures++; $display("FAIL lock_hold i=%0d got addr=%h rd=%b wr=%h acc=%b%b exp addr=2000 rd=1 wr=0 acc=00", i, core_addr, core_rd, core_wr, p0_accept, p1_accept); end
      @(negedge clk);
    end
    core_accept = 1'b1;
    #1;
    checks++; if (p1_accept !== 1'b1 || p0_accept !== 1'b0) begin failures++; $display("FAIL lock_release got=%b%b exp=01", p0_accept, p1_accept); end
    @(negedge clk);
    p1_rd = 1'b0;
    #1;
    checks++; if (p0_accept !== 1'b1 || core_wr !== 4'h3 || core_addr !== 32'h3000) begin
      failures++; $display("FAIL lock_next got=%b/%h/%h exp=1/3/3000", p0_accept, core_wr, core_addr); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_fifo_full();
    do_reset();
    p0_rd = 1'b1; core_accept = 1'b1;
    for (int i = 0; i < 4; i++) begin
      p0_addr = 32'h40 * i;
      #1;
      checks++; if (p0_accept !== 1'b1) begin failures++; $display("FAIL full_fill i=%0d got=%b exp=1", i, p0_accept); end
      @(negedge clk);
    end
    p0_addr = 32'h400;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (core_rd !== 1'b0 || p0_accept !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL full_block i=%0d got rd=%b acc=%b busy=%b exp 0 0 1", i, core_rd, p0_accept, busy); end
      @(negedge clk);
    end
    core_ack = 1'b1;
    #1;
    checks++; if (p0_ack !== 1'b1 || p0_accept !== 1'b0 || core_rd !== 1'b0) begin
      failures++; $display("FAIL full_pop got ack=%b acc=%b rd=%b exp 1 0 0", p0_ack, p0_accept, core_rd); end
    @(negedge clk);
    core_ack = 1'b0;
    #1;
    checks++; if (p0_accept !== 1'b1 || core_rd !== 1'b1 || core_addr !== 32'h400) begin
      failures++; $display("FAIL full_fifth got acc=%b rd=%b addr=%h exp 1 1 400", p0_accept, core_rd, core_addr); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_spurious_ack();
    do_reset();
    core_ack = 1'b1; core_error = 1'b1;
    #1;
    checks++; if (p0_ack !== 1'b0 || p1_ack !== 1'b0 || p0_err !== 1'b0 || p1_err !== 1'b0) begin
      failures++; $display("FAIL spur_ack got=%b%b%b%b exp=0000", p0_ack, p1_ack, p0_err, p1_err); end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL spur_proto_pre got=%b exp=0", proto_err); end
    @(negedge clk);
    core_ack = 1'b0; core_error = 1'b0;
    #1;
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL spur_proto_set got=%b exp=1", proto_err); end
    repeat (5) @(negedge clk);
    #1;
    checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL spur_proto_sticky got=%b exp=1", proto_err); end
    do_reset();
    #1;
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL spur_proto_clr got=%b exp=0", proto_err); end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    do_reset();
    p0_rd = 1'b1; core_accept = 1'b1;
    for (int i = 0; i < 2; i++) begin
      p0_addr = 32'h500 + 4 * i;
      #1;
      checks++; if (p0_accept !== 1'b1) begin failures++; $display("FAIL mid_fill i=%0d got=%b exp=1", i, p0_accept); end
      @(negedge clk);
    end
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=1", busy); end
    rst_n = 1'b0; core_ack = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || p0_accept !== 1'b0 || core_rd !== 1'b0 || core_wr !== 4'h0 || p0_ack !== 1'b0 || p1_ack !== 1'b0) begin
      failures++; $display("FAIL mid_rst_out got busy=%b acc=%b rd=%b wr=%h ack=%b%b exp all 0", busy, p0_accept, core_rd, core_wr, p0_ack, p1_ack); end
    @(negedge clk);
    core_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    p1_rd = 1'b1; p1_addr = 32'h600;
    #1;
    checks++; if (p0_accept !== 1'b1 || p1_accept !== 1'b0) begin failures++; $display("FAIL mid_first_arb got=%b%b exp=10", p0_accept, p1_accept); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_random();
    bit          pend[2];
    logic [3:0]  rwr[2];
    logic        rrd[2];
    logic [31:0] raddr[2], rwd[2];
    int          last, lockp, g, due;
    int          iss_q[$];
    int          due_q[$];
    bit          full, present, acc, h;
    logic [3:0]  exp_wr;
    logic        exp_rd;
    do_reset();
    pend[0] = 0; pend[1] = 0;
    last = 1; lockp = -1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1;
          rwr[p] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
          rrd[p] = (rwr[p] == 4'h0) ? 1'b1 : 1'($urandom_range(0, 1));
          raddr[p] = $urandom;
          rwd[p] = $urandom;
        end
      end
      p0_wr = pend[0] ? rwr[0] : 4'h0; p0_rd = pend[0] ? rrd[0] : 1'b0;
      p0_addr = raddr[0]; p0_wdata = rwd[0];
      p1_wr = pend[1] ? rwr[1] : 4'h0; p1_rd = pend[1] ? rrd[1] : 1'b0;
      p1_addr = raddr[1]; p1_wdata = rwd[1];
      core_accept = ($urandom_range(0, 3) != 0);
      core_ack = (due_q.size() > 0 && due_q[0] <= cyc);
      core_error = 1'($urandom_range(0, 1));
      core_rdata = $urandom;
      #1;
      full = (iss_q.size() == 4);
      if (lockp >= 0) g = lockp;
      else if (pend[0] && pend[1]) g = 1 - last;
      else g = pend[1] ? 1 : 0;
      present = pend[g] && !full;
      acc = present && core_accept;
      exp_wr = present ? rwr[g] : 4'h0;
      exp_rd = present && rrd[g] && (rwr[g] == 4'h0);
      checks++; if (p0_accept !== (acc && g == 0) || p1_accept !== (acc && g == 1)) begin
        failures++; $display("FAIL rnd_accept cyc=%0d got=%b%b exp=%b%b", cyc, p0_accept, p1_accept, acc && g == 0, acc && g == 1); end
      checks++; if (core_wr !== exp_wr || core_rd !== exp_rd) begin
        failures++; $display("FAIL rnd_core_cmd cyc=%0d got=%h/%b exp=%h/%b", cyc, core_wr, core_rd, exp_wr, exp_rd); end
      if (present) begin
        checks++; if (core_addr !== raddr[g] || core_wdata !== rwd[g]) begin
          failures++; $display("FAIL rnd_core_fields cyc=%0d got=%h/%h exp=%h/%h", cyc, core_addr, core_wdata, raddr[g], rwd[g]); end
      end
      if (core_ack) begin
        h = iss_q[0];
        checks++; if (p0_ack !== (h == 0) || p1_ack !== (h == 1) || p0_err !== (h == 0 && core_error) || p1_err !== (h == 1 && core_error)) begin
          failures++; $display("FAIL rnd_resp cyc=%0d got ack=%b%b err=%b%b issuer=%0d err_in=%b", cyc, p0_ack, p1_ack, p0_err, p1_err, h, core_error); end
      end else begin
        checks++; if (p0_ack !== 1'b0 || p1_ack !== 1'b0 || p0_err !== 1'b0 || p1_err !== 1'b0) begin
          failures++; $display("FAIL rnd_no_resp cyc=%0d got ack=%b%b err=%b%b exp 0", cyc, p0_ack, p1_ack, p0_err, p1_err); end
      end
      checks++; if (busy !== (iss_q.size() != 0) || p0_rdata !== core_rdata || p1_rdata !== core_rdata) begin
        failures++; $display("FAIL rnd_status cyc=%0d got busy=%b rdata=%h/%h exp busy=%b rdata=%h", cyc, busy, p0_rdata, p1_rdata, iss_q.size() != 0, core_rdata); end
      if (core_ack) begin
        void'(iss_q.pop_front());
        void'(due_q.pop_front());
      end
      if (acc) begin
        iss_q.push_back(g);
        due = cyc + $urandom_range(1, 6);
        if (due_q.size() > 0 && due <= due_q[$]) due = due_q[$] + 1;
        due_q.push_back(due);
        last = g;
        lockp = -1;
        pend[g] = 0;
      end else if (present) begin
        lockp = g;
      end
      @(negedge clk);
    end
    checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rnd_proto got=%b exp=0", proto_err); end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_port();
    test_contention();
    test_lock();
    test_fifo_full();
    test_spurious_ack();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
